// File: rtl/apb_pkg.sv
// Shared definitions for the APB register bridge: FSM encoding, word-address
// offset and the address legality check used at setup time.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_ERR
  } state_e;

  localparam int ADDR_LSB = 2;

  // addr is zero-extended by the caller; only the low addr_w bits are significant.
  function automatic logic bad_addr(input logic [63:0] addr, input int addr_w,
                                    input int regsel_w, input int num_regs);
    logic [63:0] a, hi, idx, amask, imask;
    amask = (addr_w >= 64) ? {64{1'b1}} : ((64'd1 << addr_w) - 64'd1);
    imask = (64'd1 << regsel_w) - 64'd1;
    a     = addr & amask;
    idx   = (a >> ADDR_LSB) & imask;
    hi    = a >> (regsel_w + ADDR_LSB);
    return (a[ADDR_LSB-1:0] != '0) || (hi != '0) || (idx >= 64'(num_regs));
  endfunction

endpackage

// File: rtl/apb_reg_bridge_if.sv
// APB slave signals plus the peripheral request/acknowledge bus of the bridge.
// slave = the bridge, master = the APB master and peripheral around it.
interface apb_reg_bridge_if #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int REG_DW   = 8,
  parameter int NUM_SEL  = 2,
  parameter int REGSEL_W = 2
);
  logic [ADDR_W-1:0]   PADDR;
  logic [DATA_W-1:0]   PWDATA;
  logic                PWRITE;
  logic [NUM_SEL-1:0]  PSEL;
  logic                PENABLE;
  logic [2:0]          PPROT;
  logic [DATA_W-1:0]   PRDATA;
  logic                PREADY;
  logic                PSLVERR;
  logic [REGSEL_W-1:0] REGSEL;
  logic                BUSREQ;
  logic                BUSW;
  logic [REG_DW-1:0]   BUSWDATA;
  logic [REG_DW-1:0]   BUSRDATA;
  logic                BUSACK;
  logic                BUSERR;

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE, PPROT, BUSRDATA, BUSACK, BUSERR,
    output PRDATA, PREADY, PSLVERR, REGSEL, BUSREQ, BUSW, BUSWDATA
  );

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE, PPROT, BUSRDATA, BUSACK, BUSERR,
    input  PRDATA, PREADY, PSLVERR, REGSEL, BUSREQ, BUSW, BUSWDATA
  );
endinterface

// File: rtl/apb_timeout_cnt.sv
// Cycle counter for the REQ wait; expired_o flags the last cycle allowed
// before the bridge gives up on the peripheral.
module apb_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni)                  cnt_q <= '0;
    else if (clr_i)               cnt_q <= '0;
    else if (en_i && !expired_o)  cnt_q <= cnt_q + CW'(1);

  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/apb_reg_bridge.sv
// APB slave bridging one PSEL bit onto a req/ack peripheral register bus.
// Define APB_PROT_CHECK_EN to reject unprivileged writes (PPROT[0]=0).
module apb_reg_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int REG_DW   = 8,
  parameter int NUM_SEL  = 2,
  parameter int SEL_IDX  = 0,
  parameter int REGSEL_W = 2,
  parameter int NUM_REGS = 4,
  parameter int TIMEOUT  = 15
) (
  input logic             PCLK,
  input logic             PRESETn,
  apb_reg_bridge_if.slave bus
);
  logic [ADDR_W-1:0]   paddr_w;
  logic [NUM_SEL-1:0]  psel_w;
  logic [REGSEL_W-1:0] idx_w;
  logic                sel_w, setup_w, reject_w, expired_w, unused_w;

  state_e              state_q;
  logic                busreq_q, busw_q, pready_q, pslverr_q;
  logic [REGSEL_W-1:0] regsel_q;
  logic [REG_DW-1:0]   buswdata_q;
  logic [DATA_W-1:0]   prdata_q;

  assign paddr_w = bus.PADDR;
  assign psel_w  = bus.PSEL;
  assign sel_w   = psel_w[SEL_IDX];
  assign setup_w = sel_w & ~bus.PENABLE;
  assign idx_w   = paddr_w[ADDR_LSB +: REGSEL_W];

`ifdef APB_PROT_CHECK_EN
  assign reject_w = bad_addr(64'(paddr_w), ADDR_W, REGSEL_W, NUM_REGS)
                  | (bus.PWRITE & ~bus.PPROT[0]);
`else
  assign reject_w = bad_addr(64'(paddr_w), ADDR_W, REGSEL_W, NUM_REGS);
`endif

  assign unused_w = ^{psel_w, bus.PWDATA, bus.PPROT};

  apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i     (PCLK),
    .rst_ni    (PRESETn),
    .clr_i     (state_q != ST_REQ),
    .en_i      (state_q == ST_REQ),
    .expired_o (expired_w)
  );

  // Completion outputs are one-cycle pulses, so they default low each edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= ST_IDLE;
      busreq_q   <= 1'b0;
      busw_q     <= 1'b0;
      regsel_q   <= '0;
      buswdata_q <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      case (state_q)
        ST_IDLE: if (setup_w) begin
          regsel_q   <= idx_w;
          busw_q     <= bus.PWRITE;
          buswdata_q <= bus.PWDATA[REG_DW-1:0];
          if (reject_w) begin
            state_q   <= ST_ERR;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
          end else begin
            state_q  <= ST_REQ;
            busreq_q <= 1'b1;
          end
        end
        ST_REQ: begin
          // An abort beats a late ack; an ack beats the timeout.
          if (!sel_w) begin
            state_q  <= ST_IDLE;
            busreq_q <= 1'b0;
          end else if (bus.BUSACK) begin
            state_q   <= ST_RESP;
            busreq_q  <= 1'b0;
            pready_q  <= 1'b1;
            pslverr_q <= bus.BUSERR;
            if (!busw_q) prdata_q <= DATA_W'(bus.BUSRDATA);
          end else if (expired_w) begin
            state_q   <= ST_ERR;
            busreq_q  <= 1'b0;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.PRDATA   = prdata_q;
  assign bus.PREADY   = pready_q;
  assign bus.PSLVERR  = pslverr_q;
  assign bus.REGSEL   = regsel_q;
  assign bus.BUSREQ   = busreq_q;
  assign bus.BUSW     = busw_q;
  assign bus.BUSWDATA = buswdata_q;
endmodule

// File: tb/tb_apb_reg_bridge.sv
// Bench for apb_reg_bridge: transfers are planned into a per-cycle timeline of
// expected outputs, which one negedge process compares against the DUT.
module tb_apb_reg_bridge;
  localparam int ADDR_W = 32, DATA_W = 32, REG_DW = 8, NUM_SEL = 2, SEL_IDX = 0;
  localparam int REGSEL_W = 2, NUM_REGS = 4, TIMEOUT = 15, NCYC = 8192;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;

  apb_reg_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_DW(REG_DW),
                      .NUM_SEL(NUM_SEL), .REGSEL_W(REGSEL_W)) bus ();

  apb_reg_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_DW(REG_DW), .NUM_SEL(NUM_SEL),
                   .SEL_IDX(SEL_IDX), .REGSEL_W(REGSEL_W), .NUM_REGS(NUM_REGS),
                   .TIMEOUT(TIMEOUT)) dut (.PCLK(PCLK), .PRESETn(PRESETn), .bus(bus));

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  bit                exp_busreq [NCYC];
  bit                exp_pready [NCYC];
  bit                exp_pslverr[NCYC];
  bit                exp_busw   [NCYC];
  bit [DATA_W-1:0]   exp_prdata [NCYC];
  bit [REGSEL_W-1:0] exp_regsel [NCYC];
  bit [REG_DW-1:0]   exp_bwd    [NCYC];
  int n_pass = 0, n_chk = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
  endtask

  always @(negedge PCLK) if (cyc < NCYC) begin
    chk("busreq",  bus.BUSREQ,  exp_busreq[cyc]);
    chk("pready",  bus.PREADY,  exp_pready[cyc]);
    chk("pslverr", bus.PSLVERR, exp_pslverr[cyc]);
    chk("prdata",  bus.PRDATA,  exp_prdata[cyc]);
    if (exp_busreq[cyc]) begin
      chk("regsel",   bus.REGSEL,   exp_regsel[cyc]);
      chk("busw",     bus.BUSW,     exp_busw[cyc]);
      chk("buswdata", bus.BUSWDATA, exp_bwd[cyc]);
    end
  end

  // Timeline model: setup in cycle c, peripheral acks dly cycles after BUSREQ rises.
  task automatic plan(input int c, input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                      input logic [2:0] prot, input int dly, input logic [7:0] rdata,
                      input bit err, output int e);
    bit rej;
    int last;
    rej = (addr % 4 != 0) || (addr >= 32'(NUM_REGS * 4));
`ifdef APB_PROT_CHECK_EN
    if (wr && !prot[0]) rej = 1'b1;
`else
    if (prot == 3'b111) rej = rej;
`endif
    if (rej) begin
      e = c + 1;
      exp_pready[e] = 1'b1;
      exp_pslverr[e] = 1'b1;
    end else begin
      last = (dly < TIMEOUT) ? c + 1 + dly : c + TIMEOUT;
      for (int k = c + 1; k <= last; k++) begin
        exp_busreq[k] = 1'b1;
        exp_regsel[k] = REGSEL_W'(addr >> 2);
        exp_busw[k]   = wr;
        exp_bwd[k]    = REG_DW'(wdata);
      end
      e = last + 1;
      exp_pready[e] = 1'b1;
      exp_pslverr[e] = (dly < TIMEOUT) ? err : 1'b1;
      exp_prdata[e] = (dly < TIMEOUT && !wr) ? DATA_W'(rdata) : '0;
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic rand_periph();
    bus.BUSACK   = 1'($urandom);
    bus.BUSRDATA = REG_DW'($urandom);
    bus.BUSERR   = 1'($urandom);
  endtask

  task automatic setup(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                       input logic [2:0] prot);
    bus.PSEL    = NUM_SEL'(1) << SEL_IDX;
    bus.PENABLE = 1'b0;
    bus.PADDR   = addr;
    bus.PWRITE  = wr;
    bus.PWDATA  = wdata;
    bus.PPROT   = prot;
  endtask

  task automatic do_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                         input logic [2:0] prot, input int dly, input logic [7:0] rdata,
                         input bit err, input bit early, output int c, output int e);
    int ack;
    tick();
    c = cyc;
    setup(addr, wr, wdata, prot);
    rand_periph();
    plan(c, addr, wr, wdata, prot, dly, rdata, err, e);
    ack = c + 1 + dly;
    for (int k = c + 1; k <= e; k++) begin
      tick();
      bus.PENABLE = 1'b1;
      if (exp_busreq[k] && k == ack) begin
        bus.BUSACK = 1'b1; bus.BUSRDATA = rdata; bus.BUSERR = err;
      end else if (exp_busreq[k]) begin
        bus.BUSACK = 1'b0; bus.BUSRDATA = REG_DW'($urandom); bus.BUSERR = 1'($urandom);
      end else rand_periph();
      // A setup presented while the bridge is responding must be ignored.
      if (k == e && early) begin
        bus.PENABLE = 1'b0;
        bus.PADDR = 32'($urandom_range(0, NUM_REGS - 1) * 4);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      bus.PSEL    = ~(NUM_SEL'(1) << SEL_IDX) & NUM_SEL'($urandom);
      bus.PENABLE = 1'($urandom);
      bus.PADDR   = 32'($urandom_range(0, 15));
      bus.PWRITE  = 1'($urandom);
      rand_periph();
    end
  endtask

  initial begin
    int c, e, n, dly, r;
    logic [31:0] addr;
    bus.PSEL = '0; bus.PENABLE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    bus.PWRITE = 1'b0; bus.PPROT = 3'b0; bus.BUSACK = 1'b0; bus.BUSRDATA = '0; bus.BUSERR = 1'b0;
    #1;
    chk("rst_busreq", bus.BUSREQ, 0);   chk("rst_pready", bus.PREADY, 0);
    chk("rst_pslverr", bus.PSLVERR, 0); chk("rst_prdata", bus.PRDATA, 0);
    chk("rst_regsel", bus.REGSEL, 0);   chk("rst_busw", bus.BUSW, 0);
    chk("rst_buswdata", bus.BUSWDATA, 0);
    repeat (3) @(posedge PCLK);
    #3 PRESETn = 1'b1;
    idle(2);

    do_xfer(32'h8, 1'b1, 32'h000000A5, 3'b001, 0, 8'h00, 1'b0, 1'b0, c, e);
    chk("pin_wr_lat", e - c, 2);
    chk("pin_wr_regsel", exp_regsel[c + 1], 2);
    chk("pin_wr_bwd", exp_bwd[c + 1], 8'hA5);
    chk("pin_wr_ok", {exp_pready[e], exp_pslverr[e]}, 2'b10);

    do_xfer(32'h4, 1'b0, 32'h0, 3'b001, 3, 8'h3C, 1'b0, 1'b0, c, e);
    chk("pin_rd_lat", e - c, 5);
    chk("pin_rd_data", exp_prdata[e], 32'h0000003C);

    do_xfer(32'h6, 1'b0, 32'h0, 3'b001, 0, 8'h11, 1'b0, 1'b0, c, e);
    chk("pin_mis_lat", e - c, 1);
    chk("pin_mis_err", exp_pslverr[e], 1);
    do_xfer(32'h40, 1'b0, 32'h0, 3'b001, 0, 8'h11, 1'b0, 1'b0, c, e);
    chk("pin_oor_lat", e - c, 1);

    do_xfer(32'h0, 1'b0, 32'h0, 3'b001, 1000, 8'h11, 1'b0, 1'b0, c, e);
    n = 0;
    for (int k = c; k <= e; k++) n += int'(exp_busreq[k]);
    chk("pin_tmo_req", n, 15);
    chk("pin_tmo_lat", e - c, 16);

    do_xfer(32'hC, 1'b0, 32'h0, 3'b001, TIMEOUT - 1, 8'h5A, 1'b0, 1'b0, c, e);
    chk("pin_ackwins_err", exp_pslverr[e], 0);
    chk("pin_ackwins_data", exp_prdata[e], 32'h5A);

    // Master abort: PSEL dropped during the wait, no PREADY follows.
    tick(); c = cyc;
    setup(32'hC, 1'b0, 32'h77, 3'b001); bus.BUSACK = 1'b0;
    for (int k = c + 1; k <= c + 3; k++) begin
      exp_busreq[k] = 1'b1; exp_regsel[k] = 2'd3; exp_busw[k] = 1'b0; exp_bwd[k] = 8'h77;
    end
    tick(); bus.PENABLE = 1'b1; bus.BUSACK = 1'b0;
    tick(); bus.BUSACK = 1'b0;
    tick(); bus.PSEL = '0; bus.PENABLE = 1'b0; bus.BUSACK = 1'b0;
    idle(2);

    // Reset while waiting on the peripheral.
    tick(); c = cyc;
    setup(32'h0, 1'b1, 32'h33, 3'b001); bus.BUSACK = 1'b0;
    exp_busreq[c + 1] = 1'b1; exp_regsel[c + 1] = 2'd0; exp_busw[c + 1] = 1'b1; exp_bwd[c + 1] = 8'h33;
    tick(); bus.PENABLE = 1'b1; bus.BUSACK = 1'b0;
    tick();
    #1 PRESETn = 1'b0;
    #1;
    chk("arst_busreq", bus.BUSREQ, 0);
    chk("arst_pready", bus.PREADY, 0);
    chk("arst_pslverr", bus.PSLVERR, 0);
    bus.PSEL = '0; bus.PENABLE = 1'b0;
    tick(); tick();
    #2 PRESETn = 1'b1;
    do_xfer(32'h4, 1'b0, 32'h0, 3'b001, 1, 8'hC3, 1'b0, 1'b0, c, e);
    chk("pin_post_rst_lat", e - c, 3);

`ifdef APB_PROT_CHECK_EN
    do_xfer(32'h4, 1'b1, 32'h12, 3'b000, 0, 8'h00, 1'b0, 1'b0, c, e);
    chk("pin_prot_lat", e - c, 1);
    chk("pin_prot_noreq", exp_busreq[c + 1], 0);
    do_xfer(32'h4, 1'b1, 32'h12, 3'b001, 0, 8'h00, 1'b0, 1'b0, c, e);
    chk("pin_prot_ok_lat", e - c, 2);
`endif

    for (int i = 0; i < 150 && cyc < NCYC - 100; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      addr = 32'($urandom_range(0, NUM_REGS - 1) * 4);
      else if (r == 6) addr = 32'($urandom_range(0, NUM_REGS - 1) * 4 + $urandom_range(1, 3));
      else if (r == 7) addr = 32'($urandom_range(16, 255));
      else if (r == 8) addr = $urandom;
      else             addr = 32'h1 << $urandom_range(4, 31);
      r = $urandom_range(0, 9);
      if (r <= 6)      dly = $urandom_range(0, 4);
      else if (r == 7) dly = TIMEOUT - 1;
      else if (r == 8) dly = TIMEOUT - 2;
      else             dly = TIMEOUT + $urandom_range(0, 3);
      do_xfer(addr, 1'($urandom), $urandom, 3'($urandom), dly, 8'($urandom), 1'($urandom),
              ($urandom_range(0, 9) == 0), c, e);
      idle($urandom_range(0, 2));
    end

    bus.PSEL = '0; bus.PENABLE = 1'b0;
    idle(3);
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end
endmodule

// File: doc/apb_reg_bridge.md
Name: apb_reg_bridge

Overview:
- Parametrised APB slave that bridges one PSEL channel onto a simple request/acknowledge register bus driving a peripheral (GPIO, UART, ...).
- Successor to the fixed 8-bit, two-register APB front end.
- Adds PENABLE-correct setup/access phasing, peripheral back-pressure via BUSACK, address range checking, and a timeout with PSLVERR.

Parameters:
ADDR_W, 32, APB address width; must exceed REGSEL_W+2
DATA_W, 32, APB data width
REG_DW, 8, peripheral bus data width; REG_DW <= DATA_W
NUM_SEL, 2, width of the PSEL vector
SEL_IDX, 0, PSEL bit this slave responds to
REGSEL_W, 2, register index width
NUM_REGS, 4, implemented registers; NUM_REGS <= 2**REGSEL_W
TIMEOUT, 15, cycles in REQ without BUSACK before error; minimum 1

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
PADDR  in  ADDR_W  APB address
PWDATA  in  DATA_W  APB write data
PWRITE  in  1  1 = write
PSEL  in  NUM_SEL  slave selects
PENABLE  in  1  APB access phase
PPROT  in  3  protection attributes
PRDATA  out  DATA_W  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  transfer error
REGSEL  out  REGSEL_W  peripheral register index
BUSREQ  out  1  peripheral request
BUSW  out  1  1 = peripheral write
BUSWDATA  out  REG_DW  peripheral write data
BUSRDATA  in  REG_DW  peripheral read data, valid when BUSACK=1
BUSACK  in  1  peripheral acknowledge
BUSERR  in  1  peripheral error, qualified by BUSACK

Behaviour:
- Interface: one clock, PCLK; reset PRESETn is asynchronous and active-low.
- Reset: all outputs 0; state IDLE; timeout counter 0. Reset asserted mid-transfer drops BUSREQ immediately, with no completion.
- Selection: sel = PSEL[SEL_IDX].
- Address decode: idx = PADDR[REGSEL_W+1:2]. Bad address if any of:
  - PADDR[1:0] != 0
  - PADDR[ADDR_W-1:REGSEL_W+2] != 0
  - idx >= NUM_REGS
- States: IDLE, REQ, RESP, ERR.
- IDLE: on an edge where sel & !PENABLE (setup phase):
  - Register REGSEL=idx, BUSW=PWRITE, BUSWDATA=PWDATA[REG_DW-1:0].
  - Bad address -> ERR. Otherwise -> REQ, with the counter cleared.
- REQ:
  - BUSREQ=1; REGSEL, BUSW and BUSWDATA held stable; counter increments each cycle.
  - BUSACK=1 -> RESP. On a read, capture BUSRDATA zero-extended into PRDATA. Latch BUSERR.
  - Counter reaches TIMEOUT with no BUSACK -> ERR, with BUSREQ dropped.
  - sel falls (master abort) -> IDLE, with no PREADY.
- RESP: PREADY=1 for exactly one cycle; PSLVERR = latched BUSERR; then -> IDLE.
- ERR: PREADY=1 and PSLVERR=1 for one cycle; PRDATA=0; then -> IDLE.
- Outputs outside RESP/ERR: PREADY=0, PSLVERR=0, PRDATA=0.
- Latency: minimum one wait state. Setup at cycle 0; BUSREQ high in cycle 1; BUSACK in cycle 1 gives PREADY in cycle 2.
- Boundary cases:
  - BUSACK in the same cycle the timeout is reached: BUSACK wins.
  - Back-to-back transfers: a new setup is accepted only in IDLE, so a setup during RESP is seen on the following edge.
  - BUSACK while not in REQ: ignored.

Optional Feature:
- Macro: APB_PROT_CHECK_EN.
- Defined: in IDLE, a setup with PPROT[0]=0 (unprivileged) and PWRITE=1 -> ERR, with no BUSREQ. Unprivileged reads are allowed.
- Undefined: PPROT is ignored.

Decomposition:
- Package apb_pkg holds:
  - the state encoding (IDLE/REQ/RESP/ERR)
  - the ADDR_LSB=2 constant
  - a bad-address check function parameterised by widths
- Sub-module apb_timeout_cnt: counter with clear/enable inputs and an expired output, width $clog2(TIMEOUT+1).

Test Plan:
- Write PADDR=0x8, PWDATA=0xA5, BUSACK tied 1 -> BUSREQ in cycle 1, REGSEL=2, BUSWDATA=0xA5; PREADY=1, PSLVERR=0 in cycle 2.
- Read PADDR=0x4, BUSACK after 3 cycles with BUSRDATA=0x3C -> PRDATA=0x0000003C with PREADY in the cycle after BUSACK.
- Read PADDR=0x6 or 0x40 -> no BUSREQ; PREADY=1, PSLVERR=1 in cycle 1; PRDATA=0.
- BUSACK held 0, TIMEOUT=15 -> BUSREQ high 15 cycles, then PREADY=1, PSLVERR=1, BUSREQ=0.
- PRESETn low during REQ -> BUSREQ, PREADY and PSLVERR are 0 immediately; the next transfer completes normally.
- With APB_PROT_CHECK_EN: write with PPROT=3'b000 -> PSLVERR=1, no BUSREQ. Same access with PPROT=3'b001 -> normal completion.
